// File: rtl/switch_gate_debounced.sv
// Debounced switch pairs driving LEDs through a runtime-selected AND/OR/XOR/TOGGLE gate.
// Optional macro SW_SYNC_EN inserts a 2-flop synchroniser on every switch input.

module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sample,
  output logic o_level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;

  // Accept on the edge where the run of differing samples reaches DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (i_sample != lvl_q) begin
      if (cnt_q == LAST) lvl_d = i_sample;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign o_level = lvl_q;
endmodule

module pair_gate (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_a,
  input  logic       i_b,
  input  logic [1:0] i_mode,
  output logic       o_led
);
  typedef enum logic [1:0] {
    MODE_AND = 2'b00,
    MODE_OR  = 2'b01,
    MODE_XOR = 2'b10,
    MODE_TOG = 2'b11
  } gate_mode_e;

  logic led_q, led_d;
  logic and_prev_q, and_prev_d;
  logic tog_q, tog_d;
  logic ab;

  always_comb begin
    ab         = i_a & i_b;
    and_prev_d = ab;
    tog_d      = tog_q;
    led_d      = 1'b0;
    case (gate_mode_e'(i_mode))
      MODE_AND: led_d = ab;
      MODE_OR:  led_d = i_a | i_b;
      MODE_XOR: led_d = i_a ^ i_b;
      MODE_TOG: led_d = tog_q;
      default:  led_d = 1'b0;
    endcase
    // Press = rising edge of the pair AND, only counted while in toggle mode.
    if (gate_mode_e'(i_mode) == MODE_TOG && ab && !and_prev_q) tog_d = ~tog_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      led_q      <= 1'b0;
      and_prev_q <= 1'b0;
      tog_q      <= 1'b0;
    end else begin
      led_q      <= led_d;
      and_prev_q <= and_prev_d;
      tog_q      <= tog_d;
    end
  end

  assign o_led = led_q;
endmodule

module switch_gate_debounced #(
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [NUM_SW-1:0]   i_Switch,
  input  logic [1:0]          i_Mode,
  output logic [NUM_SW-1:0]   o_Sw_Db,
  output logic [NUM_SW/2-1:0] o_LED
);
  localparam int NUM_PAIRS = NUM_SW / 2;

  logic [NUM_SW-1:0] sw_smp;

`ifdef SW_SYNC_EN
  logic [NUM_SW-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = i_Switch;
    sync2_d = sync1_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sw_smp = sync2_q;
`else
  assign sw_smp = i_Switch;
`endif

  for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_clk    (i_Clk),
      .i_rst    (i_Rst),
      .i_sample (sw_smp[s]),
      .o_level  (o_Sw_Db[s])
    );
  end

  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
    pair_gate u_gate (
      .i_clk  (i_Clk),
      .i_rst  (i_Rst),
      .i_a    (o_Sw_Db[2*k]),
      .i_b    (o_Sw_Db[2*k+1]),
      .i_mode (i_Mode),
      .o_led  (o_LED[k])
    );
  end
endmodule

// File: tb/tb_switch_gate_debounced.sv
// Bench for switch_gate_debounced: directed table of multi-cycle vectors, then random
// stimulus compared every cycle against a behavioural model.

module tb_switch_gate_debounced;
  localparam int NSW = 4;
  localparam int NP  = NSW / 2;
  localparam int DB  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NSW-1:0] sw;
  logic [1:0]     mode;
  logic [NSW-1:0] sw_db;
  logic [NP-1:0]  led;

  int checks = 0;
  int errors = 0;

  switch_gate_debounced #(.NUM_SW(NSW), .DEBOUNCE_CYCLES(DB)) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Switch (sw),
    .i_Mode   (mode),
    .o_Sw_Db  (sw_db),
    .o_LED    (led)
  );

  always #5 clk = ~clk;

  // Behavioural model: a switch is accepted once it has been seen at the opposite
  // level for DB consecutive samples; toggle state is the parity of counted presses.
  bit         m_db    [NSW];
  bit         run_q   [NSW][$];
  bit         m_led   [NP];
  bit         m_andp  [NP];
  int         presses [NP];

  task automatic model_step(input bit r, input bit [NSW-1:0] s, input bit [1:0] md);
    bit a, b, ab;
    if (r) begin
      for (int i = 0; i < NSW; i++) begin m_db[i] = 0; run_q[i].delete(); end
      for (int k = 0; k < NP; k++) begin m_led[k] = 0; m_andp[k] = 0; presses[k] = 0; end
      return;
    end
    for (int k = 0; k < NP; k++) begin
      a  = m_db[2*k];
      b  = m_db[2*k+1];
      ab = a & b;
      case (md)
        2'd0: m_led[k] = ab;
        2'd1: m_led[k] = a | b;
        2'd2: m_led[k] = a ^ b;
        default: m_led[k] = presses[k][0];
      endcase
      if (md == 2'd3 && ab && !m_andp[k]) presses[k]++;
      m_andp[k] = ab;
    end
    for (int i = 0; i < NSW; i++) begin
      if (s[i] != m_db[i]) begin
        run_q[i].push_back(s[i]);
        if (run_q[i].size() == DB) begin
          m_db[i] = s[i];
          run_q[i].delete();
        end
      end else begin
        run_q[i].delete();
      end
    end
  endtask

  function automatic bit [NSW-1:0] model_db();
    bit [NSW-1:0] v;
    for (int i = 0; i < NSW; i++) v[i] = m_db[i];
    return v;
  endfunction

  function automatic bit [NP-1:0] model_led();
    bit [NP-1:0] v;
    for (int k = 0; k < NP; k++) v[k] = m_led[k];
    return v;
  endfunction

  task automatic apply(input bit r, input bit [NSW-1:0] s, input bit [1:0] md);
    @(negedge clk);
    rst  = r;
    sw   = s;
    mode = md;
    @(posedge clk);
    model_step(r, s, md);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit           rst;
    bit [NSW-1:0] sw;
    bit [1:0]     mode;
    int           edges;
    bit [NSW-1:0] exp_db;
    bit [NP-1:0]  exp_led;
    string        name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; sw = '0; mode = 2'b00;

    // reset and release with all switches high
    vecs.push_back('{1, 4'hF, 2'd0, 2, 4'h0, 2'b00, "rst_hold"});
    vecs.push_back('{0, 4'hF, 2'd0, 3, 4'h0, 2'b00, "rst_rel_3edges"});
    vecs.push_back('{0, 4'hF, 2'd0, 1, 4'hF, 2'b00, "rst_rel_db"});
    vecs.push_back('{0, 4'hF, 2'd0, 1, 4'hF, 2'b11, "rst_rel_led"});
    // glitch rejection, then exact-length pulse acceptance
    vecs.push_back('{1, 4'h0, 2'd0, 1, 4'h0, 2'b00, "glitch_rst"});
    vecs.push_back('{0, 4'h0, 2'd0, 3, 4'h0, 2'b00, "glitch_settle"});
    vecs.push_back('{0, 4'h1, 2'd0, 3, 4'h0, 2'b00, "glitch_3"});
    vecs.push_back('{0, 4'h0, 2'd0, 6, 4'h0, 2'b00, "glitch_after"});
    vecs.push_back('{0, 4'h1, 2'd0, 4, 4'h1, 2'b00, "pulse_4"});
    vecs.push_back('{0, 4'h0, 2'd0, 4, 4'h0, 2'b00, "pulse_4_fall"});
    // mode sweep
    vecs.push_back('{0, 4'h6, 2'd0, 4, 4'h6, 2'b00, "mode_db6"});
    vecs.push_back('{0, 4'h6, 2'd0, 1, 4'h6, 2'b00, "mode_and"});
    vecs.push_back('{0, 4'h6, 2'd1, 1, 4'h6, 2'b11, "mode_or"});
    vecs.push_back('{0, 4'h6, 2'd2, 1, 4'h6, 2'b11, "mode_xor"});
    vecs.push_back('{0, 4'h3, 2'd2, 3, 4'h6, 2'b11, "mode_xor_hold"});
    vecs.push_back('{0, 4'h3, 2'd2, 1, 4'h3, 2'b11, "mode_xor_db3"});
    vecs.push_back('{0, 4'h3, 2'd2, 1, 4'h3, 2'b00, "mode_xor_3"});
    // toggle: entering with pair held must not count as a press
    vecs.push_back('{0, 4'h0, 2'd3, 6, 4'h0, 2'b00, "tog_enter"});
    vecs.push_back('{0, 4'h3, 2'd3, 6, 4'h3, 2'b01, "tog_press1"});
    vecs.push_back('{0, 4'h0, 2'd3, 6, 4'h0, 2'b01, "tog_rel1"});
    vecs.push_back('{0, 4'h3, 2'd3, 6, 4'h3, 2'b00, "tog_press2"});
    vecs.push_back('{0, 4'h0, 2'd3, 6, 4'h0, 2'b00, "tog_rel2"});
    vecs.push_back('{0, 4'h3, 2'd3, 6, 4'h3, 2'b01, "tog_press3"});
    vecs.push_back('{0, 4'h0, 2'd3, 6, 4'h0, 2'b01, "tog_rel3"});
    vecs.push_back('{0, 4'h0, 2'd0, 1, 4'h0, 2'b00, "tog_to_and"});
    vecs.push_back('{0, 4'h0, 2'd3, 1, 4'h0, 2'b01, "tog_restore"});
    // reset mid-debounce and toggle clear
    vecs.push_back('{1, 4'h0, 2'd3, 1, 4'h0, 2'b00, "mid_rst"});
    vecs.push_back('{0, 4'h0, 2'd3, 2, 4'h0, 2'b00, "mid_tog_clr"});
    vecs.push_back('{0, 4'h1, 2'd0, 2, 4'h0, 2'b00, "mid_cnt2"});
    vecs.push_back('{1, 4'h1, 2'd0, 1, 4'h0, 2'b00, "mid_rst2"});
    vecs.push_back('{0, 4'h1, 2'd0, 3, 4'h0, 2'b00, "mid_restart3"});
    vecs.push_back('{0, 4'h1, 2'd0, 1, 4'h1, 2'b00, "mid_restart4"});

    foreach (vecs[i]) begin
      for (int e = 0; e < vecs[i].edges; e++) apply(vecs[i].rst, vecs[i].sw, vecs[i].mode);
      chk({vecs[i].name, ".db"},  int'(sw_db), int'(vecs[i].exp_db));
      chk({vecs[i].name, ".led"}, int'(led),   int'(vecs[i].exp_led));
    end

    // random phase against the model
    apply(1'b1, '0, 2'd0);
    for (int n = 0; n < 400; n++) begin
      bit [NSW-1:0] s;
      bit [1:0]     md;
      bit           r;
      int           hold;
      s    = NSW'($urandom_range(0, (1 << NSW) - 1));
      md   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd3;
      r    = ($urandom_range(0, 60) == 0);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        apply(r && h == 0, s, md);
        chk("rand.db",  int'(sw_db), int'(model_db()));
        chk("rand.led", int'(led),   int'(model_led()));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
